// File: rtl/seq_pkg.sv
// +--------------------------------------------------------------------+
// | seq_pkg: shared state type and successor-map constants for the     |
// | 0->4->7->2->3 sequence checker.                                     |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package seq_pkg;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } seq_state_t;

  localparam logic [2:0] SEQ_START = 3'd0;
  localparam logic [2:0] SEQ_LAST  = 3'd3;

  // Successor of each legal value; 1, 5 and 6 have none.
  localparam logic [2:0] SEQ_SUCC_0 = 3'd4;
  localparam logic [2:0] SEQ_SUCC_4 = 3'd7;
  localparam logic [2:0] SEQ_SUCC_7 = 3'd2;
  localparam logic [2:0] SEQ_SUCC_2 = 3'd3;
  localparam logic [2:0] SEQ_SUCC_3 = 3'd0;

endpackage

`default_nettype wire

// File: rtl/seq_next_lut.sv
// +--------------------------------------------------------------------+
// | seq_next_lut: combinational successor map with a legality flag.    |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_next_lut
  import seq_pkg::*;
(
  input  logic [2:0] cur,
  output logic [2:0] nxt,
  output logic       legal
);

  always_comb begin
    nxt   = 3'd0;
    legal = 1'b1;
    case (cur)
      3'd0:    nxt = SEQ_SUCC_0;
      3'd4:    nxt = SEQ_SUCC_4;
      3'd7:    nxt = SEQ_SUCC_7;
      3'd2:    nxt = SEQ_SUCC_2;
      3'd3:    nxt = SEQ_SUCC_3;
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_checker.sv
// +--------------------------------------------------------------------+
// | seq_checker: tracks the 0->4->7->2->3 counter stream, counts laps  |
// | and flags breaks. Optional err_cnt under SEQ_CHK_ERR_CNT_EN.        |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_checker
  import seq_pkg::*;
#(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       q_in,
  output logic             locked,
  output logic [2:0]       expected,
  output logic             err_pulse,
  output logic [LAP_W-1:0] lap_cnt
`ifdef SEQ_CHK_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  if (LAP_W < 1) begin : g_bad_lap_w
    $error("seq_checker: LAP_W must be at least 1");
  end
  if (ERR_W < 1) begin : g_bad_err_w
    $error("seq_checker: ERR_W must be at least 1");
  end

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [2:0]       w_exp_nxt;
  logic             w_err_nxt;
  logic [LAP_W-1:0] w_lap_nxt;
  logic [2:0]       w_lut_nxt;
  logic             w_lut_legal;

  seq_next_lut u_lut (
    .cur   (q_in),
    .nxt   (w_lut_nxt),
    .legal (w_lut_legal)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = expected;
    w_err_nxt   = 1'b0;
    w_lap_nxt   = lap_cnt;
    if (en) begin
      case (r_state)
        ST_SEARCH: begin
          if (q_in == SEQ_START) begin
            w_state_nxt = ST_LOCKED;
            w_exp_nxt   = w_lut_nxt;
          end
        end
        ST_LOCKED: begin
          if (w_lut_legal && (q_in == expected)) begin
            w_exp_nxt = w_lut_nxt;
            if (q_in == SEQ_LAST) begin
              w_lap_nxt = lap_cnt + LAP_W'(1);
            end
          end else begin
            // The breaking sample is consumed here; relock waits for a new 0.
            w_state_nxt = ST_SEARCH;
            w_exp_nxt   = 3'd0;
            w_err_nxt   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_exp_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_SEARCH;
      expected  <= 3'd0;
      err_pulse <= 1'b0;
      lap_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      expected  <= w_exp_nxt;
      err_pulse <= w_err_nxt;
      lap_cnt   <= w_lap_nxt;
    end
  end

  assign locked = (r_state == ST_LOCKED);

`ifdef SEQ_CHK_ERR_CNT_EN
  // Saturates rather than wraps so a long fault burst is never hidden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (w_err_nxt && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire
